// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM driving datapath enables, selects and ALUOp
module multicycle_control #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Opcode,
    input  logic [OP_W-1:0] Funct,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            ZeroExt,
    output logic [1:0]      PCSource,
    output logic [3:0]      ALUOp,
    output logic            InstrDone,
    output logic            Error,
    output logic [ST_W-1:0] State
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = ST_W'(0),
        S_DECODE  = ST_W'(1),
        S_MEMADDR = ST_W'(2),
        S_MEMRD   = ST_W'(3),
        S_MEMWB   = ST_W'(4),
        S_MEMWR   = ST_W'(5),
        S_REX     = ST_W'(6),
        S_RWB     = ST_W'(7),
        S_BEQ     = ST_W'(8),
        S_JMP     = ST_W'(9),
        S_IEX     = ST_W'(10),
        S_IWB     = ST_W'(11),
        S_JR      = ST_W'(12),
        S_ERR     = ST_W'(13)
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'('h0A);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'('h0C);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'('h0F);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);
    localparam logic [OP_W-1:0] FN_JR    = OP_W'('h08);

    state_t state_q, state_d;

    // Branch condition is applied in the datapath, so Zero is not consumed here.
    logic unused_zero;
    assign unused_zero = Zero;

    function automatic logic [3:0] imm_aluop(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI: imm_aluop = 4'd3;
            OP_SLTI: imm_aluop = 4'd4;
            OP_ANDI: imm_aluop = 4'd5;
            OP_ORI:  imm_aluop = 4'd6;
            OP_LUI:  imm_aluop = 4'd7;
            default: imm_aluop = 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = (Funct == FN_JR) ? S_JR : S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEX;
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEMADDR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (MemReady) state_d = S_MEMWB;
            S_MEMWR:   if (MemReady) state_d = S_FETCH;
            S_REX:     state_d = S_RWB;
            S_IEX:     state_d = S_IWB;
            S_MEMWB, S_RWB, S_BEQ, S_JMP, S_JR, S_IWB: state_d = S_FETCH;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ZeroExt     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 4'd0;
        InstrDone   = 1'b0;
        Error       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'd2;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 4'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
            end
            S_JMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            S_JR: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b11;
                InstrDone = 1'b1;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = imm_aluop(Opcode);
                ZeroExt = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
            end
            // IR is not rewritten until the next fetch, so Opcode still selects the op.
            S_IWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                ALUOp     = imm_aluop(Opcode);
                ZeroExt   = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
            end
            S_ERR:   Error = 1'b1;
            default: Error = 1'b1;
        endcase
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b01;
            ZeroExt     = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 4'd0;
            InstrDone   = 1'b0;
            Error       = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed assertion bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic       Zero, MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, InstrDone, Error;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp, State;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.OP_W(6), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
        .PCSource(PCSource), .ALUOp(ALUOp), .InstrDone(InstrDone),
        .Error(Error), .State(State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv;
        @(negedge clk);
        #1;
    endtask

    logic [5:0] imm_op [5];
    logic [3:0] imm_alu [5];
    logic       imm_zx [5];

    initial begin
        imm_op  = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
        imm_alu = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        imm_zx  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        adv;
        chk("rst_state", State, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        reset = 1'b0; Opcode = 6'h23;
        #1;
        chk("fetch_memread", MemRead, 1);
        chk("fetch_alusrcb", ALUSrcB, 1);
        chk("fetch_irwrite", IRWrite, 1);

        // lw
        adv; chk("lw_s1", State, 1); chk("lw_dec_srcb", ALUSrcB, 3);
        adv; chk("lw_s2", State, 2); chk("lw_aluop", ALUOp, 0); chk("lw_srcb", ALUSrcB, 2);
        adv; chk("lw_s3", State, 3); chk("lw_memread", MemRead, 1); chk("lw_iord", IorD, 1);
        adv; chk("lw_s4", State, 4); chk("lw_regwrite", RegWrite, 1);
        chk("lw_memtoreg", MemtoReg, 1); chk("lw_done", InstrDone, 1);
        Opcode = 6'h00; Funct = 6'h20;
        adv; chk("lw_s0", State, 0); chk("lw_done_off", InstrDone, 0);

        // R-type add
        adv; chk("r_s1", State, 1);
        adv; chk("r_s6", State, 6); chk("r_aluop", ALUOp, 2);
        adv; chk("r_s7", State, 7); chk("r_regdst", RegDst, 1); chk("r_done", InstrDone, 1);
        Funct = 6'h08;
        adv; chk("r_s0", State, 0);

        // jr
        adv; chk("jr_s1", State, 1);
        adv; chk("jr_s12", State, 12); chk("jr_pcsrc", PCSource, 3);
        chk("jr_pcwrite", PCWrite, 1); chk("jr_done", InstrDone, 1);
        adv; chk("jr_s0", State, 0);

        // immediates
        for (int i = 0; i < 5; i++) begin
            Opcode = imm_op[i];
            adv; chk("imm_s1", State, 1);
            adv; chk("imm_s10", State, 10);
            chk("imm_aluop", ALUOp, imm_alu[i]); chk("imm_zx", ZeroExt, imm_zx[i]);
            adv; chk("imm_s11", State, 11);
            chk("imm_wb_aluop", ALUOp, imm_alu[i]); chk("imm_wb_zx", ZeroExt, imm_zx[i]);
            chk("imm_regwrite", RegWrite, 1); chk("imm_done", InstrDone, 1);
            adv; chk("imm_s0", State, 0);
        end

        // fetch wait then beq
        Opcode = 6'h04; MemReady = 1'b0;
        #1; chk("fw_ir0", IRWrite, 0); chk("fw_mr0", MemRead, 1);
        adv; chk("fw_state1", State, 0); chk("fw_ir1", IRWrite, 0);
        adv; chk("fw_state2", State, 0); chk("fw_ir2", IRWrite, 0);
        MemReady = 1'b1;
        #1; chk("fw_ir3", IRWrite, 1); chk("fw_pc3", PCWrite, 1);
        adv; chk("beq_s1", State, 1);
        adv; chk("beq_s8", State, 8); chk("beq_aluop", ALUOp, 1);
        chk("beq_pwc", PCWriteCond, 1); chk("beq_pcsrc", PCSource, 1); chk("beq_done", InstrDone, 1);
        Opcode = 6'h2B;
        adv; chk("beq_s0", State, 0);

        // sw with two wait cycles in MEMWR
        adv; chk("sw_s1", State, 1);
        adv; chk("sw_s2", State, 2);
        MemReady = 1'b0;
        adv; chk("sw_w1_state", State, 5); chk("sw_w1_mw", MemWrite, 1);
        chk("sw_w1_iord", IorD, 1); chk("sw_w1_done", InstrDone, 0);
        adv; chk("sw_w2_state", State, 5); chk("sw_w2_mw", MemWrite, 1); chk("sw_w2_done", InstrDone, 0);
        MemReady = 1'b1;
        #1; chk("sw_w3_mw", MemWrite, 1); chk("sw_w3_done", InstrDone, 1);
        Opcode = 6'h02;
        adv; chk("sw_s0", State, 0);

        // j
        adv; chk("j_s1", State, 1);
        adv; chk("j_s9", State, 9); chk("j_pcsrc", PCSource, 2); chk("j_pcwrite", PCWrite, 1);
        Opcode = 6'h3F;
        adv; chk("j_s0", State, 0);

        // illegal opcode
        adv; chk("ill_s1", State, 1);
        for (int i = 0; i < 3; i++) begin
            adv; chk("ill_state", State, 13); chk("ill_error", Error, 1);
            chk("ill_done", InstrDone, 0); chk("ill_memread", MemRead, 0);
        end

        // reset out of ERR
        reset = 1'b1;
        #1; chk("rerr_error", Error, 0); chk("rerr_memread", MemRead, 0);
        chk("rerr_pcwrite", PCWrite, 0); chk("rerr_srcb", ALUSrcB, 1);
        adv; chk("rerr_s0a", State, 0); chk("rerr_err_a", Error, 0);
        adv; chk("rerr_s0b", State, 0);
        reset = 1'b0;
        #1; chk("post_memread", MemRead, 1); chk("post_srcb", ALUSrcB, 1); chk("post_error", Error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
